// File: rtl/hz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hz_pkg;

  // Result kind of an in-flight instruction, as seen by the consumer in ID.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_ALU  = 2'd1,
    K_LOAD = 2'd2,
    K_LINK = 2'd3
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;

  localparam logic [1:0] FWD_RS  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_PC4 = 2'b11;

  // Destination register and result kind of one pipeline slot.
  typedef struct packed {
    logic [4:0] rd;
    kind_e      kind;
  } trk_t;

  localparam trk_t TRK_NONE = '{rd: 5'd0, kind: K_NONE};

  // Operand source choice plus which stage's pc+4 to use when the source is FWD_PC4.
  typedef struct packed {
    logic [1:0] sel;
    logic       pc_sel;
  } fwd_t;

  // Pick the operand source for one source register. The younger producer (EX) wins.
  // A LOAD match in EX yields FWD_RS here; the load-use stall bubbles that cycle anyway.
  function automatic fwd_t fwd_pick(logic [4:0] rs, logic used, trk_t ex, trk_t mem);
    fwd_t f;
    f = '{sel: FWD_RS, pc_sel: 1'b0};
    if (used && rs != 5'd0) begin
      if (ex.kind != K_NONE && ex.rd == rs) begin
        if (ex.kind == K_ALU) begin
          f.sel = FWD_MEM;
        end else if (ex.kind == K_LINK) begin
          f.sel = FWD_PC4;
        end
      end else if (mem.kind != K_NONE && mem.rd == rs) begin
        if (mem.kind == K_LINK) begin
          f.sel    = FWD_PC4;
          f.pc_sel = 1'b1;
        end else begin
          f.sel = FWD_WB;
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/hz_decode.sv
// Combinational decode of the ID instruction into register fields and result kind.
module hz_decode
  import hz_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rs1_used,
  output logic        rs2_used,
  output kind_e       kind
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // funct3/funct7 do not influence hazard detection.
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  // Classify which source fields are real reads and what kind of result is produced.
  always_comb begin
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    kind     = K_NONE;
    case (opcode)
      OP_LOAD:                         kind = K_LOAD;
      OP_JAL, OP_JALR:                 kind = K_LINK;
      OP_R, OP_I, OP_LUI, OP_AUIPC:    kind = K_ALU;
      default:                         kind = K_NONE;
    endcase
    // Writes to x0 never produce a forwardable result.
    if (rd == 5'd0) begin
      kind = K_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: load-use stalls, branch flushes,
// registered forwarding selects for EX, and stall/flush event counters.
module hazard_ctrl
  import hz_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr_ID,
  input  logic             i_br_taken,
  input  logic             i_mem_stall,
  output logic             o_stall_pc,
  output logic             o_stall_all,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic [1:0]       o_forward_a_sel,
  output logic [1:0]       o_forward_b_sel,
  output logic             o_pc_plus_4_sela,
  output logic             o_pc_plus_4_selb,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_rs1_used;
  logic       id_rs2_used;
  kind_e      id_kind;

  trk_t ex_q;
  trk_t mem_q;
  trk_t wb_q;

  fwd_t fwd_a;
  fwd_t fwd_b;

  logic load_use;
  logic br_act;
  logic lu_act;
  logic unused_wb;

  hz_decode u_decode (
    .instr    (i_instr_ID),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd       (id_rd),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .kind     (id_kind)
  );

  // The register file writes before it is read, so WB never needs a bypass into ID;
  // wb_q is carried only to keep the three-slot history complete.
  assign unused_wb = ^wb_q;

  assign fwd_a = fwd_pick(id_rs1, id_rs1_used, ex_q, mem_q);
  assign fwd_b = fwd_pick(id_rs2, id_rs2_used, ex_q, mem_q);

  // Detect a consumer in ID of a load result still in EX; resolve priority mem > branch > load-use.
  always_comb begin
    load_use = 1'b0;
    if (ex_q.kind == K_LOAD) begin
      load_use = (id_rs1_used && id_rs1 != 5'd0 && id_rs1 == ex_q.rd) ||
                 (id_rs2_used && id_rs2 != 5'd0 && id_rs2 == ex_q.rd);
    end
    br_act = i_br_taken && !i_mem_stall;
    lu_act = load_use && !i_br_taken && !i_mem_stall;
  end

  // Stall/flush strobes; all held low while reset is asserted.
  always_comb begin
    o_stall_all = i_rst_n && i_mem_stall;
    o_stall_pc  = i_rst_n && (i_mem_stall || lu_act);
    o_flush_id  = i_rst_n && br_act;
    o_flush_ex  = i_rst_n && (br_act || lu_act);
  end

  // Advance the trackers and register the selects for the instruction entering EX.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q             <= TRK_NONE;
      mem_q            <= TRK_NONE;
      wb_q             <= TRK_NONE;
      o_forward_a_sel  <= FWD_RS;
      o_forward_b_sel  <= FWD_RS;
      o_pc_plus_4_sela <= 1'b0;
      o_pc_plus_4_selb <= 1'b0;
    end else if (!i_mem_stall) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (br_act || lu_act) begin
        ex_q             <= TRK_NONE;
        o_forward_a_sel  <= FWD_RS;
        o_forward_b_sel  <= FWD_RS;
        o_pc_plus_4_sela <= 1'b0;
        o_pc_plus_4_selb <= 1'b0;
      end else begin
        ex_q             <= trk_t'{rd: (id_kind == K_NONE) ? 5'd0 : id_rd, kind: id_kind};
        o_forward_a_sel  <= fwd_a.sel;
        o_forward_b_sel  <= fwd_b.sel;
        o_pc_plus_4_sela <= fwd_a.pc_sel;
        o_pc_plus_4_selb <= fwd_b.pc_sel;
      end
    end
  end

  // Count cycles spent in load-use stall and in branch flush; wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (lu_act) begin
        o_stall_cnt <= o_stall_cnt + 1'b1;
      end
      if (br_act) begin
        o_flush_cnt <= o_flush_cnt + 1'b1;
      end
    end
  end

endmodule
